// File: rtl/fetch_if.sv
// fetch_if: bundles the IF-stage control inputs, instruction ROM bus and
// IF/ID register outputs of fetch_stage.
//   master : the fetch stage (drives imem_addr_o and the IF/ID fields)
//   slave  : hazard/branch logic, instruction ROM and decode
// Signals:
//   stall_i, flush_i, redirect_i, redirect_pc_i    control from EX/hazard unit
//   imem_addr_o / imem_rdata_i                     combinational ROM port
//   instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o     IF/ID register
//   misalign_o                                     sticky misaligned-target flag
//   fetch_cnt_o, bubble_cnt_o                      only with FETCH_PERF_CNT_EN
interface fetch_if;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_d_o;
    logic [31:0] pc_d_o;
    logic [31:0] pc_plus4_d_o;
    logic        valid_d_o;
    logic        misalign_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;
`endif

    modport master (
`ifdef FETCH_PERF_CNT_EN
        output fetch_cnt_o,
        output bubble_cnt_o,
`endif
        input  stall_i,
        input  flush_i,
        input  redirect_i,
        input  redirect_pc_i,
        output imem_addr_o,
        input  imem_rdata_i,
        output instr_d_o,
        output pc_d_o,
        output pc_plus4_d_o,
        output valid_d_o,
        output misalign_o
    );

    modport slave (
`ifdef FETCH_PERF_CNT_EN
        input  fetch_cnt_o,
        input  bubble_cnt_o,
`endif
        output stall_i,
        output flush_i,
        output redirect_i,
        output redirect_pc_i,
        input  imem_addr_o,
        output imem_rdata_i,
        input  instr_d_o,
        input  pc_d_o,
        input  pc_plus4_d_o,
        input  valid_d_o,
        input  misalign_o
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the RV32IM 5-stage pipeline.
// Holds the PC, presents it to the combinational instruction ROM and captures
// the returned word, its PC and PC+4 into the IF/ID register one cycle later.
// Ports:
//   clk  - pipeline clock (rising edge)
//   rst  - synchronous active-high reset
//   bus  - fetch_if.master: stall/flush/redirect control, ROM port, IF/ID outputs,
//          sticky misalign flag
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_cnt_o and
// bubble_cnt_o performance counters to the interface.
// Priority per edge: rst > redirect > stall > advance for the PC;
//                    rst > redirect|flush > stall > capture for IF/ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic   clk,
    input  logic   rst,
    fetch_if.master bus
);

    logic [31:0] pc_q;
    logic [31:0] pc_next4;
    logic [31:0] instr_p1;
    logic [31:0] pc_p1;
    logic [31:0] pc_plus4_p1;
    logic        vld_p1;
    logic        misalign_q;
    logic        bubble_load;
    logic        capture;

    // Wraps naturally modulo 2^32.
    assign pc_next4    = pc_q + 32'd4;
    assign bubble_load = bus.redirect_i | bus.flush_i;
    assign capture     = ~bubble_load & ~bus.stall_i;

    // ---- IF: program counter ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (bus.redirect_i) begin
            // Low bits are dropped; a misaligned target is only flagged.
            pc_q <= {bus.redirect_pc_i[31:2], 2'b00};
        end else if (!bus.stall_i) begin
            pc_q <= pc_next4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    // ---- IF/ID boundary ----
    // A bubble keeps the previous pc/pc+4; only instr and valid are squashed.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_p1    <= NOP_INSTR;
            pc_p1       <= 32'd0;
            pc_plus4_p1 <= 32'd0;
            vld_p1      <= 1'b0;
        end else if (bubble_load) begin
            instr_p1    <= NOP_INSTR;
            vld_p1      <= 1'b0;
        end else if (capture) begin
            instr_p1    <= bus.imem_rdata_i;
            pc_p1       <= pc_q;
            pc_plus4_p1 <= pc_next4;
            vld_p1      <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            if (capture)     fetch_cnt_q  <= fetch_cnt_q + 32'd1;
            if (bubble_load) bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign bus.fetch_cnt_o  = fetch_cnt_q;
    assign bus.bubble_cnt_o = bubble_cnt_q;
`endif

    assign bus.imem_addr_o  = pc_q;
    assign bus.instr_d_o    = instr_p1;
    assign bus.pc_d_o       = pc_p1;
    assign bus.pc_plus4_d_o = pc_plus4_p1;
    assign bus.valid_d_o    = vld_p1;
    assign bus.misalign_o   = misalign_q;

endmodule
